// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS485 transmit path.
package rs485_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_LEAD,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_TAIL
    } tx_state_t;

    typedef enum logic {
        BYTE_HI,
        BYTE_LO
    } byte_sel_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic TX_IDLE        = 1'b1;

endpackage

// File: rtl/rs485_baud_tick.sv
// Free-running bit-period counter; restart holds it at zero so the first bit of a frame is full length.
module rs485_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_bit_tick,
    output logic o_pre_tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    // pre_tick marks the second-to-last cycle so registered outputs can land on the last one.
    assign o_bit_tick = (r_count == LAST);
    assign o_pre_tick = (r_count == PRE);

endmodule

// File: rtl/rs485_frame_tx.sv
// Pops 16-bit words from the FIFO and sends each as two 8N1 frames (high byte first),
// managing the half-duplex driver enable with lead and tail guard times.
module rs485_frame_tx
    import rs485_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int LEAD_BITS    = 1,
    parameter int TAIL_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    input  logic [15:0] fifo_data,
    output logic        tx,
    output logic        tx_enable,
    output logic        busy,
    output logic        tx_complete,
    output logic [15:0] words_sent
);

    localparam int LEAD_CYC  = LEAD_BITS * CLKS_PER_BIT;
    localparam int TAIL_CYC  = TAIL_BITS * CLKS_PER_BIT;
    localparam int GUARD_MAX = (LEAD_CYC > TAIL_CYC) ? LEAD_CYC : TAIL_CYC;
    localparam int GW        = (GUARD_MAX > 1) ? $clog2(GUARD_MAX) : 1;
    localparam logic [GW-1:0] LEAD_LAST = GW'((LEAD_CYC > 0) ? LEAD_CYC - 1 : 0);
    localparam logic [GW-1:0] TAIL_LAST = GW'((TAIL_CYC > 0) ? TAIL_CYC - 1 : 0);

    tx_state_t   r_state;
    byte_sel_t   r_byte_sel;
    logic [15:0] r_shreg;
    logic [7:0]  r_byte;
    logic [2:0]  r_bit_cnt;
    logic [GW-1:0] r_guard;
    logic        r_tx;
    logic        r_tx_enable;
    logic        r_fifo_rd;
    logic        r_busy;
    logic        r_tx_complete;
    logic [15:0] r_words_sent;

    logic        w_restart;
    logic        w_bit_tick;
    logic        w_pre_tick;
    logic        w_can_start;
    logic [7:0]  w_cur_byte;

    assign w_restart   = (r_state == ST_IDLE) || (r_state == ST_FETCH) || (r_state == ST_LOAD);
    assign w_can_start = enable && !fifo_empty;
    assign w_cur_byte  = (r_byte_sel == BYTE_HI) ? r_shreg[15:8] : r_shreg[7:0];

    rs485_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_restart  (w_restart),
        .o_bit_tick (w_bit_tick),
        .o_pre_tick (w_pre_tick)
    );

    // Every output is set on the edge that enters the state it belongs to, so all are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_byte_sel    <= BYTE_HI;
            r_shreg       <= '0;
            r_byte        <= '0;
            r_bit_cnt     <= '0;
            r_guard       <= '0;
            r_tx          <= TX_IDLE;
            r_tx_enable   <= 1'b0;
            r_fifo_rd     <= 1'b0;
            r_busy        <= 1'b0;
            r_tx_complete <= 1'b0;
            r_words_sent  <= '0;
        end else begin
            r_fifo_rd     <= 1'b0;
            r_tx_complete <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_can_start) begin
                        r_state   <= ST_FETCH;
                        r_fifo_rd <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_shreg     <= fifo_data;
                    r_byte_sel  <= BYTE_HI;
                    r_tx_enable <= 1'b1;
                    // A driver that is already on means we are mid-burst: no lead time.
                    if (r_tx_enable || (LEAD_CYC == 0)) begin
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                    end else begin
                        r_state <= ST_LEAD;
                        r_guard <= '0;
                    end
                end
                ST_LEAD: begin
                    if (r_guard == LEAD_LAST) begin
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                    end else begin
                        r_guard <= r_guard + GW'(1);
                    end
                end
                ST_START: begin
                    if (w_bit_tick) begin
                        r_state   <= ST_DATA;
                        r_tx      <= w_cur_byte[0];
                        r_byte    <= w_cur_byte >> 1;
                        r_bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                            r_state <= ST_STOP;
                            r_tx    <= TX_IDLE;
                        end else begin
                            r_tx      <= r_byte[0];
                            r_byte    <= r_byte >> 1;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if ((r_byte_sel == BYTE_LO) && w_pre_tick) begin
                        r_tx_complete <= 1'b1;
                        r_words_sent  <= r_words_sent + 16'd1;
                    end
                    if (w_bit_tick) begin
                        if (r_byte_sel == BYTE_HI) begin
                            r_byte_sel <= BYTE_LO;
                            r_state    <= ST_START;
                            r_tx       <= 1'b0;
                        end else if (w_can_start) begin
                            r_state   <= ST_FETCH;
                            r_fifo_rd <= 1'b1;
                        end else if (TAIL_CYC == 0) begin
                            r_state     <= ST_IDLE;
                            r_tx_enable <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_state <= ST_TAIL;
                            r_guard <= '0;
                        end
                    end
                end
                ST_TAIL: begin
                    if (r_guard == TAIL_LAST) begin
                        r_state     <= ST_IDLE;
                        r_tx_enable <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_guard <= r_guard + GW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx          = r_tx;
    assign tx_enable   = r_tx_enable;
    assign fifo_rd     = r_fifo_rd;
    assign busy        = r_busy;
    assign tx_complete = r_tx_complete;
    assign words_sent  = r_words_sent;

endmodule
